// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO. The frame format
// (length, parity, stop bits) is latched per frame when an entry is popped.
// Break generation is built only when the TX_BREAK_EN macro is defined;
// otherwise break_i is accepted but ignored.
module uart_tx_fifo #(
  parameter int unsigned MAX_DATA_W = 9,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        baud_en_i,
  input  logic                        tx_en_i,
  input  logic [5:0]                  tx_conf_i,
  input  logic                        tx_valid_i,
  input  logic [MAX_DATA_W-1:0]       tx_data_i,
  output logic                        tx_ready_o,
  input  logic                        break_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        busy_o,
  output logic                        tx_done_o,
  output logic                        uart_tx_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OsW  = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  // FIFO storage and bookkeeping
  logic [MAX_DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [PtrW:0]         level_q;
  logic                  push, pop;

  // Frame FSM state
  state_e                state_q, state_d;
  logic [OsW-1:0]        os_cnt_q, os_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0]            nbits_q, nbits_d;
  logic [MAX_DATA_W-1:0] shift_q, shift_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic                  stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic [MAX_DATA_W-1:0] head, data_masked;
  logic [3:0]            len_dec;
  logic                  par_calc;
  logic                  bit_end;
  logic                  brk_req;

`ifdef TX_BREAK_EN
  logic brk_hi_q, brk_hi_d;
  assign brk_req = break_i;
`else
  logic unused_break;
  assign unused_break = break_i;
  assign brk_req      = 1'b0;
`endif

  // Ready is forced low in reset so nothing is accepted while held
  assign tx_ready_o   = rst_ni & tx_en_i & (level_q < (PtrW + 1)'(FIFO_DEPTH));
  assign push         = tx_valid_i & tx_ready_o;
  assign head         = mem_q[rptr_q];
  assign fifo_level_o = level_q;
  assign busy_o       = (state_q != StIdle);
  assign tx_done_o    = done_q;
  assign uart_tx_o    = tx_q;
  assign bit_end      = (os_cnt_q == OsW'(OVERSAMPLE - 1));

  // FIFO data array, no reset needed since pointers gate every read
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= tx_data_i;
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop)      level_q <= level_q + (PtrW + 1)'(1);
      else if (!push && pop) level_q <= level_q - (PtrW + 1)'(1);
    end
  end

  // Decode the frame format of the head entry; unused lengths map to 8, then clamp
  always_comb begin
    len_dec = 4'd8;
    if (tx_conf_i[2:0] < 3'd5) len_dec = {1'b0, tx_conf_i[2:0]} + 4'd5;
    if (len_dec > 4'(MAX_DATA_W)) len_dec = 4'(MAX_DATA_W);
    for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
      data_masked[i] = head[i] & (i < 32'(len_dec));
    end
    unique case (tx_conf_i[5:4])
      2'b01:   par_calc = ^data_masked;
      2'b10:   par_calc = ~^data_masked;
      default: par_calc = 1'b1;
    endcase
  end

  // Frame FSM next state; every transition waits for a baud tick
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    pop        = 1'b0;
`ifdef TX_BREAK_EN
    brk_hi_d   = brk_hi_q;
`endif
    if (baud_en_i) begin
      os_cnt_d = bit_end ? '0 : os_cnt_q + OsW'(1);
      unique case (state_q)
        StIdle: begin
          os_cnt_d = '0;
          if (brk_req) begin
            state_d = StBreak;
            tx_d    = 1'b0;
          end else if (tx_en_i && (level_q != '0)) begin
            pop        = 1'b1;
            state_d    = StStart;
            tx_d       = 1'b0;
            nbits_d    = len_dec;
            shift_d    = data_masked;
            par_mode_d = tx_conf_i[5:4];
            stop2_d    = tx_conf_i[3];
            par_bit_d  = par_calc;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_d   = StData;
            tx_d      = shift_q[0];
            bit_cnt_d = '0;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_cnt_q == nbits_q - 4'd1) begin
              bit_cnt_d = '0;
              if (par_mode_q != 2'b00) begin
                state_d = StParity;
                tx_d    = par_bit_q;
              end else begin
                state_d = StStop;
                tx_d    = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              shift_d   = shift_q >> 1;
              tx_d      = shift_q[1];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (stop2_q && (bit_cnt_q == 4'd0)) begin
              bit_cnt_d = 4'd1;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
`ifdef TX_BREAK_EN
        StBreak: begin
          // Low phase lasts while break_i is held, then one full high bit-time
          if (!brk_hi_q) begin
            os_cnt_d = '0;
            if (!break_i) begin
              brk_hi_d = 1'b1;
              tx_d     = 1'b1;
            end
          end else if (bit_end) begin
            brk_hi_d = 1'b0;
            state_d  = StIdle;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame FSM registers; reset returns the line high at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      shift_q    <= '0;
      par_mode_q <= '0;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

`ifdef TX_BREAK_EN
  // Break phase flag: 0 while holding the line low, 1 during the trailing high bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) brk_hi_q <= 1'b0;
    else         brk_hi_q <= brk_hi_d;
  end
`endif

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The module SHALL have parameter MAX_DATA_W, default 9, meaning the widest supported data field in bits (5..9).
REQ-002 The module SHALL have parameter OVERSAMPLE, default 16, meaning baud_en_i ticks per bit (4..64).
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the input FIFO (power of two, >=2).
REQ-004 The module SHALL have port clk_i  in  1  single clock.
REQ-005 The module SHALL have port rst_ni  in  1  reset, asynchronous and active-low.
REQ-006 The module SHALL have port baud_en_i  in  1  oversample tick, one clk_i cycle wide.
REQ-007 The module SHALL have port tx_en_i  in  1  transmitter enable.
REQ-008 The module SHALL have port tx_conf_i  in  6  {parity_mode[1:0], stop2, data_len[2:0]}.
REQ-009 The module SHALL have port tx_valid_i  in  1  write request.
REQ-010 The module SHALL have port tx_data_i  in  MAX_DATA_W  write data.
REQ-011 The module SHALL have port tx_ready_o  out  1  FIFO can accept data.
REQ-012 The module SHALL have port break_i  in  1  break request.
REQ-013 The module SHALL have port fifo_level_o  out  $clog2(FIFO_DEPTH)+1  number of entries held.
REQ-014 The module SHALL have port busy_o  out  1  frame in progress.
REQ-015 The module SHALL have port tx_done_o  out  1  one-cycle end-of-frame pulse.
REQ-016 The module SHALL have port uart_tx_o  out  1  serial line, idle high.

Function
REQ-017 The FIFO SHALL write on any clk_i edge where tx_valid_i && tx_ready_o, with tx_ready_o = tx_en_i && (level < FIFO_DEPTH).
REQ-018 A simultaneous push and pop SHALL leave fifo_level_o unchanged, and the read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK, with every transition qualified by baud_en_i.
REQ-020 On a tick in IDLE with tx_en_i=1 and level>0, the FSM SHALL pop one entry, latch tx_conf_i for the frame, set busy_o and enter START.
REQ-021 Each bit SHALL last exactly OVERSAMPLE ticks; the line SHALL be 0 in START, carry data LSB-first in DATA, and be 1 in STOP and IDLE.
REQ-022 data_len SHALL be decoded as 0..4 meaning 5..9 bits; codes 5..7 SHALL be treated as 8 bits, and lengths above MAX_DATA_W SHALL be clamped to MAX_DATA_W.
REQ-023 parity_mode SHALL be decoded as 00 none (PARITY skipped), 01 even, 10 odd, 11 mark (1), with parity computed over the transmitted data bits only.
REQ-024 stop2 SHALL select 2 stop bits when 1 and 1 stop bit when 0.
REQ-025 After the last stop tick, the module SHALL pulse tx_done_o for one clk_i cycle, clear busy_o and return to IDLE.
REQ-026 Back-to-back frames SHALL start on the tick immediately after STOP ends, with no extra idle bit.
REQ-027 Deasserting tx_en_i mid-frame SHALL let the current frame complete and start no new frame, and SHALL NOT flush the FIFO.
REQ-028 A change on tx_conf_i mid-frame SHALL have no effect until the next frame.

Reset
REQ-029 While rst_ni=0, the module SHALL hold the state at IDLE, uart_tx_o=1, busy_o=0, tx_done_o=0, tx_ready_o=0, fifo_level_o=0, with pointers and counters at zero.
REQ-030 A reset asserted mid-frame SHALL drive uart_tx_o high immediately, discard the frame and FIFO contents, and leave no tx_done_o pulse.

Configuration
REQ-031 When TX_BREAK_EN is defined, a tick in IDLE with break_i=1 SHALL enter BREAK and hold the line 0 while break_i=1.
REQ-032 With TX_BREAK_EN defined, break_i=0 SHALL then be followed by one bit-time high before returning to IDLE, and busy_o SHALL be 1 throughout.
REQ-033 With TX_BREAK_EN defined, a break request during a frame SHALL take effect after that frame completes, with break taking priority over a non-empty FIFO.
REQ-034 When TX_BREAK_EN is not defined, the port break_i SHALL be present but ignored and no BREAK logic SHALL be built.

Verification
REQ-035 Bench scenario 8N1 (OVERSAMPLE=16, baud_en_i every cycle, conf=6'b000011, data 0xA5): line SHALL be 0,1,0,1,0,0,1,0,1,1 at 16 cycles per bit, with tx_done_o pulsing once after 160 ticks.
REQ-036 Bench scenario 7E2 (conf=6'b011010, data 0x41): data SHALL be 1,0,0,0,0,0,1, parity 0, then 2 stop bits, for a frame of 176 ticks.
REQ-037 Bench scenario 9O1 (conf=6'b100100, data 0x1FF): nine 1 data bits SHALL be followed by odd parity 0.
REQ-038 Bench scenario FIFO full (tx_en_i toggled so no pop occurs, 5 pushes of 0x11..0x15): tx_ready_o SHALL drop after 4 pushes, fifo_level_o=4, and 0x15 SHALL be dropped; frames SHALL then emit 0x11..0x14 in order.
REQ-039 Bench scenario reset: rst_ni pulsed low during the 3rd data bit SHALL give uart_tx_o=1, busy_o=0, fifo_level_o=0 and no tx_done_o pulse.
REQ-040 Bench scenario break (TX_BREAK_EN defined, break_i high for 40 ticks in IDLE): line SHALL be low for 40 ticks, then high for 16, then IDLE.
